dct_read_sched: RTL and testbench
=================================

# dct_read_sched

Read scheduler for the 2-D DCT datapath. It sequences SRAM reads of all 8x8 pixel blocks of the Y, Cb and Cr planes, stored interleaved at word address 3*blk + comp. It honours downstream backpressure and delivers a DCT enable strobe aligned with the returned SRAM data, tagged with component and block index. It sits between the top-level controller (start/done) and the SRAM read port and DCT input stage.

## Interface

- NUM_BLK, 575: 8x8 blocks per component plane.
- ADDR_W, 11: SRAM word address width.
- BLK_W, 10: block index width; must satisfy 2^BLK_W >= NUM_BLK.
- SRAM_LAT, 2: cycles from sram_ren/sram_raddr registered to valid data_read; minimum 1.

Ports:

- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse; starts one frame pass; sampled only in IDLE.
- stall  in  1  downstream backpressure; while high, no new read is issued.
- sram_raddr  out  ADDR_W  registered SRAM read address.
- sram_ren  out  1  registered read strobe; high when sram_raddr is a new request.
- dct_enable  out  1  data_read is valid this cycle and must be consumed by the DCT.
- tag_comp  out  2  component of the current dct_enable beat: 0=Y, 1=Cb, 2=Cr.
- tag_blk  out  BLK_W  block index of the current dct_enable beat.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the last tagged beat.

## Operation

- FSM states: IDLE, ISSUE, DRAIN, FIN.
  - IDLE -> ISSUE on start.
  - ISSUE -> DRAIN on the edge that issues the final read.
  - DRAIN -> FIN when the tag pipeline is empty.
  - FIN -> IDLE unconditionally; done=1 during FIN.
- start outside IDLE is ignored; it is neither queued nor causes a restart.
- Counters comp (0..2) and blk (0..NUM_BLK-1) clear on entry to ISSUE.
- In ISSUE, a read is issued on each edge where stall was low in the preceding cycle:
  - sram_ren<=1, sram_raddr<=3*blk+comp, truncated to ADDR_W; computed without a multiplier, by incremental add.
  - The counters advance in the order selected by Configuration.
- In ISSUE with stall high: sram_ren<=0, sram_raddr and counters hold.
- In IDLE, DRAIN and FIN: sram_ren=0 and sram_raddr holds its last value.
- Tag pipeline: a shift register of SRAM_LAT stages carrying {valid, comp, blk}, loaded on each issue.
  - dct_enable, tag_comp and tag_blk come from the last stage.
  - Tags hold their value when dct_enable is 0.
- stall does not affect reads already issued; in-flight beats always emerge. Downstream must size stall lead time to at least SRAM_LAT.
- The final read is comp=2, blk=NUM_BLK-1 in both orders; total reads = 3*NUM_BLK.
- Reset mid-operation: all state clears immediately, in-flight beats are dropped, no done is generated, and FSM returns to IDLE.

## Timing

- Reset values: sram_raddr=0, sram_ren=0, dct_enable=0, tag_comp=0, tag_blk=0, busy=0, done=0; FSM=IDLE.
- start high before edge E0: FSM=ISSUE and busy=1 after E0.
- First read (stall low): sram_ren=1 and sram_raddr=0 after E1.
- dct_enable for a read registered at edge Ek is high after edge Ek+SRAM_LAT, for exactly one cycle per read.
- No stall: sram_ren is high continuously for 3*NUM_BLK cycles.
- done and busy deassertion occur after edge E_last+SRAM_LAT+1, where E_last is the final issue edge.
  - Stall-free timing with defaults: done after edge E0+1728.
- Throughput: one read per cycle; every stall cycle adds exactly one cycle of latency.

## Configuration

- DCT_SCHED_INTERLEAVE_EN
  - Defined: block-major order; comp increments first and wraps 2->0 with blk+1. Addresses run 0,1,2,3,... sequentially.
  - Undefined (default): component-major order; blk increments first and wraps NUM_BLK-1->0 with comp+1.
    - Addresses run 0,3,...,1722, then 1,4,...,1723, then 2,...,1724.

## Test plan

- Reset, then start with no stall, default order: sram_raddr sequence 0,3,...,1722,1,...,1723,2,...,1724.
  - 1725 dct_enable beats; tags match each address delayed by 2 cycles.
  - done is a single pulse at E0+1728; busy falls with it.
- Same with DCT_SCHED_INTERLEAVE_EN defined: addresses 0..1724 in order; tags cycle comp 0,1,2 with blk incrementing every 3 beats.
- Stall high for 5 cycles mid-ISSUE at address 300:
  - sram_ren low for 5 cycles and address held.
  - Two in-flight beats still emerge.
  - Sequence resumes at 303; done is delayed by exactly 5 cycles.
- Assert start repeatedly while busy: no restart, no address discontinuity, exactly one done pulse.
- Drop rst_n asynchronously during ISSUE and mid-clock during DRAIN:
  - All outputs go to reset values immediately.
  - No dct_enable or done follows.
  - A subsequent start runs a complete, correct pass.
- NUM_BLK=2, SRAM_LAT=1 with stall toggling every cycle:
  - 6 reads issued on alternate cycles.
  - dct_enable is 1 cycle after each sram_ren.
  - done is 2 cycles after the final issue edge.

Source files
------------

// File: rtl/dct_read_sched.sv
// dct_read_sched: sequences interleaved Y/Cb/Cr block reads and tags returning SRAM data for the DCT.
// Define DCT_SCHED_INTERLEAVE_EN for block-major read order; the default is component-major.
module dct_read_sched #(
    parameter int NUM_BLK  = 575,
    parameter int ADDR_W   = 11,
    parameter int BLK_W    = 10,
    parameter int SRAM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stall,
    output logic [ADDR_W-1:0] sram_raddr,
    output logic              sram_ren,
    output logic              dct_enable,
    output logic [1:0]        tag_comp,
    output logic [BLK_W-1:0]  tag_blk,
    output logic              busy,
    output logic              done
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;
    typedef struct packed {
        logic             valid;
        logic [1:0]       comp;
        logic [BLK_W-1:0] blk;
    } tag_t;

    state_t            state, state_nxt;
    logic [1:0]        comp;
    logic [BLK_W-1:0]  blk;
    logic [ADDR_W-1:0] addr;
    tag_t              pipe [SRAM_LAT];
    logic              issue, blk_end, last, pipe_busy;

    assign issue   = state == ISSUE && !stall;
    assign blk_end = blk == BLK_W'(NUM_BLK - 1);
    assign last    = comp == 2'd2 && blk_end;
    assign busy    = state == ISSUE || state == DRAIN;
    assign done    = state == FIN;

    always_comb begin
        pipe_busy = 1'b0;
        for (int i = 0; i < SRAM_LAT; i++) pipe_busy = pipe_busy | pipe[i].valid;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? ISSUE : IDLE;
            ISSUE:   state_nxt = issue && last ? DRAIN : ISSUE;
            DRAIN:   state_nxt = pipe_busy ? DRAIN : FIN;
            default: state_nxt = IDLE;
        endcase
    end

    // addr tracks 3*blk+comp incrementally so no multiplier is needed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            comp       <= '0;
            blk        <= '0;
            addr       <= '0;
            sram_raddr <= '0;
            sram_ren   <= 1'b0;
        end else begin
            state    <= state_nxt;
            sram_ren <= issue;
            if (state == IDLE && start) begin
                comp <= '0;
                blk  <= '0;
                addr <= '0;
            end else if (issue) begin
                sram_raddr <= addr;
`ifdef DCT_SCHED_INTERLEAVE_EN
                addr <= addr + 1'b1;
                comp <= comp == 2'd2 ? 2'd0 : comp + 1'b1;
                if (comp == 2'd2) blk <= blk + 1'b1;
`else
                if (blk_end) begin
                    blk  <= '0;
                    comp <= comp + 1'b1;
                    addr <= ADDR_W'(comp) + 1'b1;
                end else begin
                    blk  <= blk + 1'b1;
                    addr <= addr + ADDR_W'(3);
                end
`endif
            end
        end
    end

    // Stage 0 loads alongside sram_ren; the output register adds the final cycle of SRAM_LAT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SRAM_LAT; i++) pipe[i] <= '0;
            dct_enable <= 1'b0;
            tag_comp   <= '0;
            tag_blk    <= '0;
        end else begin
            pipe[0] <= {issue, comp, blk};
            for (int i = 1; i < SRAM_LAT; i++) pipe[i] <= pipe[i-1];
            dct_enable <= pipe[SRAM_LAT-1].valid;
            if (pipe[SRAM_LAT-1].valid) begin
                tag_comp <= pipe[SRAM_LAT-1].comp;
                tag_blk  <= pipe[SRAM_LAT-1].blk;
            end
        end
    end
endmodule

// File: tb/tb_dct_read_sched.sv
// tb_dct_read_sched: directed checks of read order, stall, start-while-busy, async reset and a small config.
module tb_dct_read_sched;
    localparam int NB = 575, ADDR_W = 11, BLK_W = 10;

    logic clk = 0, rst_n = 0, start = 0, stall = 0, start2 = 0, stall2 = 0;
    logic [ADDR_W-1:0] sram_raddr, raddr2;
    logic sram_ren, dct_enable, busy, done, ren2, en2, busy2, done2;
    logic [1:0] tag_comp, comp2;
    logic [BLK_W-1:0] tag_blk, blk2;
    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    dct_read_sched dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
        .sram_raddr(sram_raddr), .sram_ren(sram_ren), .dct_enable(dct_enable),
        .tag_comp(tag_comp), .tag_blk(tag_blk), .busy(busy), .done(done)
    );

    dct_read_sched #(.NUM_BLK(2), .SRAM_LAT(1)) dut_small (
        .clk(clk), .rst_n(rst_n), .start(start2), .stall(stall2),
        .sram_raddr(raddr2), .sram_ren(ren2), .dct_enable(en2),
        .tag_comp(comp2), .tag_blk(blk2), .busy(busy2), .done(done2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int e_comp(input int i, input int nb);
`ifdef DCT_SCHED_INTERLEAVE_EN
        return i % 3;
`else
        return i / nb;
`endif
    endfunction

    function automatic int e_blk(input int i, input int nb);
`ifdef DCT_SCHED_INTERLEAVE_EN
        return i / 3;
`else
        return i % nb;
`endif
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_raddr"}, sram_raddr, 0);
        check({tag, "_ren"}, sram_ren, 0);
        check({tag, "_en"}, dct_enable, 0);
        check({tag, "_comp"}, tag_comp, 0);
        check({tag, "_blk"}, tag_blk, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
    endtask

    // One frame pass on the default instance; cyc counts negedges after the start-accept edge E0.
    task automatic run_pass(input int stall_addr, input int stall_len, input bit poke,
                            input int abort_cyc, input bit abort_hi);
        int n_iss = 0, n_beat = 0, stall_left = 0, stall_t = -1, ea;
        int exp_done = 3 * NB + 3 + stall_len;
        logic [ADDR_W-1:0] last_addr = '0;
        logic [1:0] ren_h = '0;
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
        for (int cyc = 0; cyc <= exp_done + 4; cyc++) begin
            if (cyc == abort_cyc) begin
                if (abort_hi) @(posedge clk);
                #2 rst_n = 0;
                #1 check_reset_outputs("abort");
                @(negedge clk); @(negedge clk); rst_n = 1;
                repeat (6) begin
                    @(negedge clk);
                    check("post_rst_en", dct_enable, 0);
                    check("post_rst_done", done, 0);
                    check("post_rst_busy", busy, 0);
                end
                return;
            end
            check("busy", busy, cyc < exp_done);
            check("done", done, cyc == exp_done);
            check("en_latency", dct_enable, ren_h[1]);
            check("ren", sram_ren, cyc >= 1 && n_iss < 3 * NB &&
                  !(stall_t >= 0 && cyc > stall_t && cyc <= stall_t + stall_len));
            ren_h = {ren_h[0], sram_ren};
            if (stall_left > 0) begin
                stall_left--;
                if (stall_left == 0) stall = 0;
            end
            if (sram_ren) begin
                ea = 3 * e_blk(n_iss, NB) + e_comp(n_iss, NB);
                check("raddr", sram_raddr, ea);
                if (ea == stall_addr && stall_len > 0) begin
                    stall = 1;
                    stall_left = stall_len;
                    stall_t = cyc;
                end
                last_addr = sram_raddr;
                n_iss++;
            end else if (n_iss > 0) check("raddr_hold", sram_raddr, last_addr);
            if (dct_enable) begin
                check("tag_comp", tag_comp, e_comp(n_beat, NB));
                check("tag_blk", tag_blk, e_blk(n_beat, NB));
                n_beat++;
            end
            start = poke && (cyc % 100 == 50 || cyc == exp_done);
            @(negedge clk);
        end
        start = 0;
        check("n_reads", n_iss, 3 * NB);
        check("n_beats", n_beat, 3 * NB);
    endtask

    // NUM_BLK=2, SRAM_LAT=1 with stall low only before odd edges
    task automatic small_pass();
        int n = 0, m = 0;
        logic r_prev = 0;
        @(negedge clk); start2 = 1;
        @(negedge clk); start2 = 0;
        for (int cyc = 0; cyc <= 16; cyc++) begin
            check("s_ren", ren2, cyc % 2 == 1 && cyc <= 11);
            check("s_en_latency", en2, r_prev);
            r_prev = ren2;
            if (ren2) begin
                check("s_raddr", raddr2, 3 * e_blk(n, 2) + e_comp(n, 2));
                n++;
            end
            if (en2) begin
                check("s_tag_comp", comp2, e_comp(m, 2));
                check("s_tag_blk", blk2, e_blk(m, 2));
                m++;
            end
            check("s_done", done2, cyc == 13);
            check("s_busy", busy2, cyc < 13);
            stall2 = cyc % 2 == 1;
            @(negedge clk);
        end
        stall2 = 0;
        check("s_n_reads", n, 6);
        check("s_n_beats", m, 6);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1;
        run_pass(-1, 0, 0, -1, 0);
        run_pass(300, 5, 0, -1, 0);
        run_pass(-1, 0, 1, -1, 0);
        run_pass(-1, 0, 0, 500, 0);
        run_pass(-1, 0, 0, 3 * NB + 1, 1);
        run_pass(-1, 0, 0, -1, 0);
        small_pass();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
